// File: rtl/pc_pkg.sv
// Shared types and default parameters for the program-counter unit.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_LD   = 3'd2,
    PC_TRAP = 3'd3,
    PC_MRET = 3'd4
  } pc_sel_e;

  localparam int          DEF_XLEN         = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int          DEF_INC          = 4;
  localparam int          DEF_RAS_DEPTH    = 4;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [XLEN-1:0] mem_r [DEPTH];
  logic [PW-1:0]   ptr_r;
  logic [CW-1:0]   cnt_r;
  logic [PW-1:0]   ptr_nxt_s;
  logic [CW-1:0]   cnt_nxt_s;
  logic [PW-1:0]   wr_idx_s;
  logic            wr_en_s;

  // Pointer/occupancy update; push+pop on a non-empty stack rewrites the top in place.
  always_comb begin
    ptr_nxt_s = ptr_r;
    cnt_nxt_s = cnt_r;
    wr_idx_s  = ptr_r;
    wr_en_s   = 1'b0;
    if (push && (!pop || (cnt_r == CNT_ZERO))) begin
      ptr_nxt_s = ptr_r + PW'(1'b1);
      wr_idx_s  = ptr_r + PW'(1'b1);
      wr_en_s   = 1'b1;
      if (cnt_r != CNT_MAX) begin
        cnt_nxt_s = cnt_r + CW'(1'b1);
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else if (push && pop) begin
      wr_en_s = 1'b1;
    end else if (pop && (cnt_r != CNT_ZERO)) begin
      ptr_nxt_s = ptr_r - PW'(1'b1);
      cnt_nxt_s = cnt_r - CW'(1'b1);
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Stack storage and pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_r <= {PW{1'b0}};
      cnt_r <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      ptr_r <= ptr_nxt_s;
      cnt_r <= cnt_nxt_s;
      if (wr_en_s) begin
        mem_r[wr_idx_s] <= push_data;
      end
    end
  end

  assign empty = (cnt_r == CNT_ZERO);
  assign full  = (cnt_r == CNT_MAX);
  assign top   = empty ? {XLEN{1'b0}} : mem_r[ptr_r];

endmodule

// File: rtl/pc_unit.sv
// Program counter with trap/mret redirection, alignment-checked loads and a return-address stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int              INC          = DEF_INC,
  parameter int              RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            inc,
  input  logic            ld,
  input  logic [XLEN-1:0] target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mret,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] count,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            misalign
);

  pc_sel_e         sel_s;
  logic [XLEN-1:0] count_r;
  logic [XLEN-1:0] epc_r;
  logic            misalign_r;
  logic [XLEN-1:0] count_nxt_s;
  logic [XLEN-1:0] epc_nxt_s;
  logic [XLEN-1:0] count_inc_s;
  logic            misalign_nxt_s;
  logic            ras_en_s;

  assign count_inc_s = count_r + XLEN'(INC);
  // A trapping cycle never touches the stack, even if push/pop are raised alongside.
  assign ras_en_s    = !stall && !trap;

  // Next-PC source selection: trap > mret > (stall) > ld > inc > hold.
  always_comb begin
    sel_s          = PC_HOLD;
    misalign_nxt_s = 1'b0;
    if (trap) begin
      sel_s = PC_TRAP;
    end else if (mret) begin
      sel_s = PC_MRET;
    end else if (stall) begin
      sel_s = PC_HOLD;
    end else if (ld) begin
      if (is_aligned(target[1:0])) begin
        sel_s = PC_LD;
      end else begin
        sel_s          = PC_HOLD;
        misalign_nxt_s = 1'b1;
      end
    end else if (inc) begin
      sel_s = PC_INC;
    end else begin
      sel_s = PC_HOLD;
    end
  end

  // Next-PC mux and exception-PC capture.
  always_comb begin
    count_nxt_s = count_r;
    epc_nxt_s   = epc_r;
    case (sel_s)
      PC_TRAP: count_nxt_s = trap_vec;
      PC_MRET: count_nxt_s = epc_r;
      PC_LD:   count_nxt_s = target;
      PC_INC:  count_nxt_s = count_inc_s;
      PC_HOLD: count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
    if (sel_s == PC_TRAP) begin
      epc_nxt_s = count_r;
    end else begin
      epc_nxt_s = epc_r;
    end
  end

  // PC, EPC and misalign registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_r    <= RESET_VECTOR;
      epc_r      <= {XLEN{1'b0}};
      misalign_r <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      epc_r      <= epc_nxt_s;
      misalign_r <= misalign_nxt_s;
    end
  end

  assign count    = count_r;
  assign epc      = epc_r;
  assign misalign = misalign_r;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rstn      (rstn),
    .push      (ras_push && ras_en_s),
    .pop       (ras_pop && ras_en_s),
    .push_data (count_inc_s),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with hand-computed expectations.
module tb_pc_unit;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        inc;
  logic        ld;
  logic [31:0] target;
  logic        trap;
  logic [31:0] trap_vec;
  logic        mret;
  logic        ras_push;
  logic        ras_pop;
  logic [31:0] count;
  logic [31:0] epc;
  logic [31:0] ras_top;
  logic        ras_empty;
  logic        ras_full;
  logic        misalign;

  int checks;
  int failures;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0200),
    .INC          (4),
    .RAS_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .stall     (stall),
    .inc       (inc),
    .ld        (ld),
    .target    (target),
    .trap      (trap),
    .trap_vec  (trap_vec),
    .mret      (mret),
    .ras_push  (ras_push),
    .ras_pop   (ras_pop),
    .count     (count),
    .epc       (epc),
    .ras_top   (ras_top),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] t);
    ld = 1'b1;
    target = t;
    step();
    ld = 1'b0;
  endtask

  initial begin
    logic [31:0] pushes [5];
    logic [31:0] pops [4];
    pushes = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
    pops   = '{32'h54, 32'h44, 32'h34, 32'h24};
    checks = 0;
    failures = 0;
    rstn = 1'b0; stall = 1'b0; inc = 1'b0; ld = 1'b0; target = 32'h0;
    trap = 1'b0; trap_vec = 32'h0; mret = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;

    #12;
    chk("rst_count", count, 32'h0000_0200);
    chk("rst_epc", epc, 32'h0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_empty", {31'd0, ras_empty}, 32'd1);
    chk("rst_full", {31'd0, ras_full}, 32'd0);
    chk("rst_top", ras_top, 32'h0);
    rstn = 1'b1;

    inc = 1'b1;
    step(); chk("inc1", count, 32'h204);
    step(); chk("inc2", count, 32'h208);
    step(); chk("inc3", count, 32'h20C);
    inc = 1'b0;

    load(32'hFFFF_FFFC);
    chk("ld_top", count, 32'hFFFF_FFFC);
    inc = 1'b1; step(); inc = 1'b0;
    chk("inc_wrap", count, 32'h0);

    load(32'h100);
    chk("ld_100", count, 32'h100);
    load(32'h402);
    chk("misal_hold", count, 32'h100);
    chk("misal_pulse", {31'd0, misalign}, 32'd1);
    step();
    chk("misal_clear", {31'd0, misalign}, 32'd0);
    stall = 1'b1; load(32'h402); stall = 1'b0;
    chk("misal_stalled", {31'd0, misalign}, 32'd0);
    load(32'h400);
    chk("ld_400", count, 32'h400);

    trap = 1'b1; trap_vec = 32'h80; stall = 1'b1; ld = 1'b1; target = 32'h800;
    step();
    trap = 1'b0; stall = 1'b0; ld = 1'b0;
    chk("trap_count", count, 32'h80);
    chk("trap_epc", epc, 32'h400);
    mret = 1'b1; step(); mret = 1'b0;
    chk("mret_count", count, 32'h400);
    chk("mret_epc", epc, 32'h400);

    stall = 1'b1; inc = 1'b1; ras_push = 1'b1;
    step();
    stall = 1'b0; inc = 1'b0; ras_push = 1'b0;
    chk("stall_count", count, 32'h400);
    chk("stall_ras", {31'd0, ras_empty}, 32'd1);

    for (int i = 0; i < 5; i++) begin
      load(pushes[i]);
      ras_push = 1'b1;
      if (i == 0) chk("ras_no_comb", {31'd0, ras_empty}, 32'd1);
      step();
      ras_push = 1'b0;
    end
    chk("ras_full", {31'd0, ras_full}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ras_pop_val", ras_top, pops[i]);
      ras_pop = 1'b1; step(); ras_pop = 1'b0;
    end
    chk("ras_empty4", {31'd0, ras_empty}, 32'd1);
    chk("ras_top_empty", ras_top, 32'h0);
    ras_pop = 1'b1; step(); ras_pop = 1'b0;
    chk("ras_underflow_empty", {31'd0, ras_empty}, 32'd1);
    chk("ras_underflow_full", {31'd0, ras_full}, 32'd0);

    load(32'h10);
    ras_push = 1'b1; step(); ras_push = 1'b0;
    chk("ras_one", ras_top, 32'h14);
    load(32'h60);
    ld = 1'b1; target = 32'h700; inc = 1'b1; ras_push = 1'b1; ras_pop = 1'b1;
    step();
    ld = 1'b0; inc = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;
    chk("combo_count", count, 32'h700);
    chk("combo_top", ras_top, 32'h64);
    chk("combo_empty", {31'd0, ras_empty}, 32'd0);
    trap = 1'b1; trap_vec = 32'h80; ras_pop = 1'b1;
    step();
    trap = 1'b0; ras_pop = 1'b0;
    chk("trap_ras_keep", ras_top, 32'h64);
    chk("trap_epc2", epc, 32'h700);
    ras_pop = 1'b1; step(); ras_pop = 1'b0;
    chk("combo_occ1", {31'd0, ras_empty}, 32'd1);

    inc = 1'b1; ras_push = 1'b1;
    rstn = 1'b0;
    #1;
    chk("midrst_count", count, 32'h200);
    chk("midrst_empty", {31'd0, ras_empty}, 32'd1);
    ras_push = 1'b0;
    #2 rstn = 1'b1;
    step();
    inc = 1'b0;
    chk("post_rst_inc", count, 32'h204);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
